fifo_queue_param: RTL and testbench
===================================

# fifo_queue_param

Parametrised synchronous FIFO queue, the next generation of the team's 8-bit/8-deep queue. Width, depth and almost-full/almost-empty thresholds are parameters. The block adds a fill count, a registered read port with a valid strobe, a synchronous flush, and sticky overflow/underflow error flags. It sits between any producer and consumer sharing one clock domain, as a general rate-matching buffer.

## Interface
- DATA_WIDTH, 8, bits per entry (>=1)
- ADDR_WIDTH, 3, depth DEPTH = 2**ADDR_WIDTH entries (>=1)
- AF_LEVEL, 6, Almost_Full asserts when Fill_Count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, Almost_Empty asserts when Fill_Count <= AE_LEVEL (0..DEPTH-1)

- Clk_In  input  1  clock, all state updates on rising edge
- Reset_In  input  1  reset, asynchronous, active-high
- Clear_In  input  1  synchronous flush, active-high, priority over read/write
- Data_In  input  DATA_WIDTH  write data
- Write_Enable_In  input  1  write request
- Read_Enable_In  input  1  read request
- Data_Out  output  DATA_WIDTH  registered read data, holds last value read
- Data_Valid_Out  output  1  one-cycle strobe, Data_Out updated this cycle
- Fill_Count  output  ADDR_WIDTH+1  entries currently stored, 0..DEPTH
- FIFO_Empty  output  1  Fill_Count == 0
- FIFO_Full  output  1  Fill_Count == DEPTH
- Almost_Full  output  1  Fill_Count >= AF_LEVEL
- Almost_Empty  output  1  Fill_Count <= AE_LEVEL
- Overflow  output  1  sticky, a write was rejected because the FIFO was full
- Underflow  output  1  sticky, a read was rejected because the FIFO was empty

## Operation
- Storage: DEPTH x DATA_WIDTH register array. No reset on array contents.
- Pointers: write and read pointers are ADDR_WIDTH+1 bits each. The low ADDR_WIDTH bits address the array; the MSB is a wrap bit.
- Fill_Count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Status outputs are combinational from the pointers.
- Read accepted (rd_ok) = Read_Enable_In && !FIFO_Empty && !Clear_In.
- Write accepted (wr_ok) = Write_Enable_In && !Clear_In && (!FIFO_Full || rd_ok). A write at full is accepted if a read is accepted in the same cycle.
- When wr_ok: mem[wr_ptr] <= Data_In, and wr_ptr increments.
- When rd_ok: Data_Out <= mem[rd_ptr], Data_Valid_Out <= 1, and rd_ptr increments. Otherwise Data_Valid_Out <= 0 and Data_Out holds its value.
- Simultaneous read and write when non-empty: both accepted and Fill_Count unchanged. At full, the read returns the oldest entry and the new entry takes the freed slot.
- Simultaneous read and write when empty: only the write is accepted. The read is rejected and Underflow sets. The written data is not bypassed to Data_Out.
- Error flags:
  - Overflow sets when Write_Enable_In && FIFO_Full && !rd_ok && !Clear_In.
  - Underflow sets when Read_Enable_In && FIFO_Empty && !Clear_In.
  - Both flags stay set until Clear_In or Reset_In.
- Clear_In: both pointers go to 0 and Overflow, Underflow and Data_Valid_Out go to 0. Data_Out holds. Any read or write in the same cycle is ignored.
- Pointer wrap: pointers roll over from 2**(ADDR_WIDTH+1)-1 to 0 naturally, with no special case.

## Timing
- Reset values:
  - Pointers = 0, Fill_Count = 0.
  - FIFO_Empty = 1, FIFO_Full = 0.
  - Almost_Empty = 1, Almost_Full = 0 (given AF_LEVEL >= 1).
  - Data_Out = 0, Data_Valid_Out = 0, Overflow = 0, Underflow = 0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The first accepted write after deassertion occurs at the first rising edge with Reset_In low.
- Write latency: data written at edge N is readable by a request sampled at edge N+1. Status flags reflect the write after edge N.
- Read latency: request sampled at edge N gives Data_Out and Data_Valid_Out valid after edge N, i.e. during cycle N+1.
- Throughput: one write and one read per cycle sustained. No bubbles at full or empty except the empty case above.

## Test plan
- Reset: assert Reset_In asynchronously mid-cycle. Required: all outputs reach their reset values before the next edge. FIFO_Empty=1, Fill_Count=0.
- Fill and overflow (defaults): write 0x10..0x17 on consecutive cycles, then write 0x18.
  - After the 8 writes: FIFO_Full=1, Fill_Count=8, Almost_Full went high after the 6th write.
  - After 0x18: Overflow=1, and 0x18 is not stored.
- Drain and underflow: read 9 times. Required: Data_Out = 0x10..0x17 in order, each with Data_Valid_Out=1. After the 8th read FIFO_Empty=1. The 9th read gives Data_Valid_Out=0, Underflow=1, Data_Out held at 0x17.
- Simultaneous at full: with 8 entries, assert write 0xAA and read together. Required: read returns the oldest entry, Fill_Count stays 8, Overflow stays 0, and 0xAA is read last after the remaining 7 entries.
- Wrap-around: stream 40 writes of an incrementing byte with reads interleaved at Fill_Count between 1 and 5. Required: read order matches write order across multiple pointer wraps, with no flag glitches.
- Clear mid-operation: with 5 entries and Overflow set, pulse Clear_In together with Write_Enable_In. Required: next cycle Fill_Count=0, FIFO_Empty=1, Overflow=0, and the write is discarded.

Source files
------------

// File: rtl/fifo_queue_param.sv
// fifo_queue_param
// Parametrised single-clock FIFO with a registered read port and a valid strobe.
// It also provides a fill count, almost-full and almost-empty thresholds,
// a synchronous flush, and sticky overflow and underflow flags.
// Both pointers carry one extra wrap bit. The fill count is their modular
// difference, so full and empty can be told apart without extra state.

module fifo_queue_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Clear_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Write_Enable_In,
   input  logic                  Read_Enable_In,
   output logic [DATA_WIDTH-1:0] Data_Out,
   output logic                  Data_Valid_Out,
   output logic [ADDR_WIDTH:0]   Fill_Count,
   output logic                  FIFO_Empty,
   output logic                  FIFO_Full,
   output logic                  Almost_Full,
   output logic                  Almost_Empty,
   output logic                  Overflow,
   output logic                  Underflow
);

   localparam int                 DEPTH    = 1 << ADDR_WIDTH;
   localparam int                 PTR_W    = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0]   DEPTH_P  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0]   AF_P     = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0]   AE_P     = PTR_W'(AE_LEVEL);

   // Storage array, deliberately left without reset
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      fill;

   logic                  rd_ok;
   logic                  wr_ok;
   logic                  ovf_set;
   logic                  udf_set;

   // Registered read port: data and its strobe travel together
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  vld_p1;
   logic                  ovf_p1;
   logic                  udf_p1;

   // Status decode straight from the pointers; modular subtraction handles wrap
   always_comb begin
      fill         = wr_ptr - rd_ptr;
      FIFO_Empty   = (fill == '0);
      FIFO_Full    = (fill == DEPTH_P);
      Almost_Full  = (fill >= AF_P);
      Almost_Empty = (fill <= AE_P);
      Fill_Count   = fill;
   end

   // Request qualification; a full FIFO still takes a write when a read frees a slot
   always_comb begin
      rd_ok   = Read_Enable_In && !FIFO_Empty && !Clear_In;
      wr_ok   = Write_Enable_In && !Clear_In && (!FIFO_Full || rd_ok);
      ovf_set = Write_Enable_In && FIFO_Full && !rd_ok && !Clear_In;
      udf_set = Read_Enable_In && FIFO_Empty && !Clear_In;
   end

   // ---- stage p0 -> array: accepted writes land in the slot under wr_ptr
   always_ff @(posedge Clk_In) begin
      if (wr_ok) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= Data_In;
      end
   end

   // Pointer update; flush returns both pointers to zero
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (Clear_In) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // ---- stage p0 -> p1: read data register holds its value between accepted reads
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         data_p1 <= '0;
      end else if (rd_ok) begin
         data_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
   end

   // Valid strobe: high for exactly the cycle after an accepted read
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_ok;
      end
   end

   // Sticky error flags, cleared only by flush or reset
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         ovf_p1 <= 1'b0;
         udf_p1 <= 1'b0;
      end else if (Clear_In) begin
         ovf_p1 <= 1'b0;
         udf_p1 <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_p1 <= 1'b1;
         end
         if (udf_set) begin
            udf_p1 <= 1'b1;
         end
      end
   end

   assign Data_Out       = data_p1;
   assign Data_Valid_Out = vld_p1;
   assign Overflow       = ovf_p1;
   assign Underflow      = udf_p1;

endmodule

// File: tb/tb_fifo_queue_param.sv
// Testbench for fifo_queue_param (default parameters: 8 bits x 8 entries, AF 6, AE 2).
// It combines a table of directed vectors, hand-written corner sequences and
// randomised traffic. The traffic is checked against a queue-based model.

module tb_fifo_queue_param;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AFL   = 6;
   localparam int AEL   = 2;

   logic          Clk_In;
   logic          Reset_In;
   logic          Clear_In;
   logic [DW-1:0] Data_In;
   logic          Write_Enable_In;
   logic          Read_Enable_In;
   logic [DW-1:0] Data_Out;
   logic          Data_Valid_Out;
   logic [AW:0]   Fill_Count;
   logic          FIFO_Empty;
   logic          FIFO_Full;
   logic          Almost_Full;
   logic          Almost_Empty;
   logic          Overflow;
   logic          Underflow;

   fifo_queue_param #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
   ) dut (
      .Clk_In(Clk_In), .Reset_In(Reset_In), .Clear_In(Clear_In),
      .Data_In(Data_In), .Write_Enable_In(Write_Enable_In),
      .Read_Enable_In(Read_Enable_In), .Data_Out(Data_Out),
      .Data_Valid_Out(Data_Valid_Out), .Fill_Count(Fill_Count),
      .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
      .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   initial begin
      Clk_In = 1'b0;
      forever #5 Clk_In = ~Clk_In;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: a plain queue plus the registered outputs
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   bit            m_vld, m_ovf, m_udf;

   typedef struct {
      int clr, we, re, din;
      int dout, vld, fill, empty, full, af, ae, ovf, udf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // Model update from the rules: clear first, then read-before-write at the same edge
   task automatic model_step(input bit clr, input bit we, input bit re, input logic [DW-1:0] din);
      int  cnt;
      bit  rd, wr;
      if (clr) begin
         q.delete();
         m_vld = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         cnt = q.size();
         rd  = re && (cnt > 0);
         wr  = we && ((cnt < DEPTH) || rd);
         if (re && cnt == 0) m_udf = 1'b1;
         if (we && cnt == DEPTH && !rd) m_ovf = 1'b1;
         if (rd) begin
            m_dout = q.pop_front();
            m_vld  = 1'b1;
         end else begin
            m_vld = 1'b0;
         end
         if (wr) q.push_back(din);
      end
   endtask

   // Apply one cycle of inputs, clock it, advance the model, settle 1 time unit past the edge
   task automatic drive(input logic clr, input logic we, input logic re, input logic [DW-1:0] din);
      Clear_In        = clr;
      Write_Enable_In = we;
      Read_Enable_In  = re;
      Data_In         = din;
      @(posedge Clk_In);
      model_step(clr, we, re, din);
      #1;
      Clear_In        = 1'b0;
      Write_Enable_In = 1'b0;
      Read_Enable_In  = 1'b0;
   endtask

   task automatic check_model(input string tag);
      int n;
      n = q.size();
      chk({tag, ".vld"},   32'(Data_Valid_Out), 32'(m_vld));
      chk({tag, ".dout"},  32'(Data_Out),       32'(m_dout));
      chk({tag, ".fill"},  32'(Fill_Count),     32'(n));
      chk({tag, ".empty"}, 32'(FIFO_Empty),     (n == 0) ? 32'd1 : 32'd0);
      chk({tag, ".full"},  32'(FIFO_Full),      (n == DEPTH) ? 32'd1 : 32'd0);
      chk({tag, ".af"},    32'(Almost_Full),    (n >= AFL) ? 32'd1 : 32'd0);
      chk({tag, ".ae"},    32'(Almost_Empty),   (n <= AEL) ? 32'd1 : 32'd0);
      chk({tag, ".ovf"},   32'(Overflow),       32'(m_ovf));
      chk({tag, ".udf"},   32'(Underflow),      32'(m_udf));
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, ".vld"},   32'(Data_Valid_Out), v.vld);
      chk({tag, ".dout"},  32'(Data_Out),       v.dout);
      chk({tag, ".fill"},  32'(Fill_Count),     v.fill);
      chk({tag, ".empty"}, 32'(FIFO_Empty),     v.empty);
      chk({tag, ".full"},  32'(FIFO_Full),      v.full);
      chk({tag, ".af"},    32'(Almost_Full),    v.af);
      chk({tag, ".ae"},    32'(Almost_Empty),   v.ae);
      chk({tag, ".ovf"},   32'(Overflow),       v.ovf);
      chk({tag, ".udf"},   32'(Underflow),      v.udf);
   endtask

   function automatic vec_t mkv(int clr, int we, int re, int din, int dout, int vld, int fill,
                                int ovf, int udf);
      vec_t v;
      v.clr  = clr;  v.we = we; v.re = re; v.din = din;
      v.dout = dout; v.vld = vld; v.fill = fill;
      v.empty = (fill == 0) ? 1 : 0;
      v.full  = (fill == DEPTH) ? 1 : 0;
      v.af    = (fill >= AFL) ? 1 : 0;
      v.ae    = (fill <= AEL) ? 1 : 0;
      v.ovf   = ovf;  v.udf = udf;
      return v;
   endfunction

   initial begin
      int           cnt;
      int           next_exp;
      int           wr_cnt;
      bit           re_r, we_r, clr_r;
      logic [DW-1:0] d;

      Reset_In        = 1'b1;
      Clear_In        = 1'b0;
      Data_In         = '0;
      Write_Enable_In = 1'b0;
      Read_Enable_In  = 1'b0;
      model_reset();

      // Reset state, sampled while reset is still held
      #7;
      check_model("reset");
      #5 Reset_In = 1'b0;

      // Directed table: fill 0x10..0x17, overflow with 0x18, drain 9 times, then flush
      for (int i = 0; i < 8; i++)
         tbl.push_back(mkv(0, 1, 0, 'h10 + i, 0, 0, i + 1, 0, 0));
      tbl.push_back(mkv(0, 1, 0, 'h18, 0, 0, 8, 1, 0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mkv(0, 0, 1, 0, 'h10 + k, 1, 7 - k, 1, 0));
      tbl.push_back(mkv(0, 0, 1, 0, 'h17, 0, 0, 1, 1));
      tbl.push_back(mkv(1, 0, 0, 0, 'h17, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(1'(tbl[i].clr), 1'(tbl[i].we), 1'(tbl[i].re), 8'(tbl[i].din));
         check_vec($sformatf("tbl%0d", i), tbl[i]);
      end

      // Simultaneous read and write at full: oldest out, 0xAA takes the freed slot
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
      check_model("simfull.pre");
      drive(1'b0, 1'b1, 1'b1, 8'hAA);
      check_model("simfull.rw");
      chk("simfull.oldest", 32'(Data_Out), 32'h20);
      chk("simfull.ovf0", 32'(Overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("simfull.rd%0d", i), 32'(Data_Out), (i == 7) ? 32'hAA : 32'(8'h21 + i));
      end
      check_model("simfull.post");

      // Simultaneous read and write when empty: write only, no bypass, underflow
      drive(1'b0, 1'b1, 1'b1, 8'h5C);
      check_model("simempty");
      chk("simempty.nobypass", 32'(Data_Valid_Out), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Wrap-around stream: 40 incrementing bytes, occupancy kept in 1..5
      next_exp = 'h40;
      wr_cnt   = 0;
      while (wr_cnt < 40 || q.size() > 0) begin
         cnt  = q.size();
         we_r = (wr_cnt < 40);
         if (!we_r)        re_r = 1'b1;
         else if (cnt >= 5) re_r = 1'b1;
         else if (cnt >= 2) re_r = bit'($urandom_range(0, 1));
         else              re_r = 1'b0;
         drive(1'b0, we_r, re_r, 8'(8'h40 + wr_cnt));
         if (we_r) wr_cnt++;
         if (Data_Valid_Out) begin
            chk("wrap.order", 32'(Data_Out), 32'(8'(next_exp)));
            next_exp++;
         end
         if (wr_cnt < 40 && wr_cnt > 0)
            chk("wrap.range", (Fill_Count >= 1 && Fill_Count <= 5) ? 32'd1 : 32'd0, 32'd1);
         check_model("wrap");
      end
      chk("wrap.count", 32'(next_exp), 32'h40 + 32'd40);

      // Clear mid-operation: 5 entries with Overflow set, clear together with a write
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
      chk("clr.pre.fill", 32'(Fill_Count), 32'd5);
      chk("clr.pre.ovf", 32'(Overflow), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 8'h99);
      check_model("clr.post");
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("clr.discard", 32'(Fill_Count), 32'd0);

      // Asynchronous reset mid-cycle with data, valid and overflow non-zero
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      chk("areset.pre.vld", 32'(Data_Valid_Out), 32'd1);
      #2 Reset_In = 1'b1;
      model_reset();
      #1;
      check_model("areset");
      #2 Reset_In = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 8'h3E);
      check_model("areset.firstwr");
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      chk("areset.rd", 32'(Data_Out), 32'h3E);

      // Randomised traffic against the model
      for (int c = 0; c < 600; c++) begin
         clr_r = ($urandom_range(0, 59) == 0);
         if ((c / 50) % 2 == 0) begin
            we_r = ($urandom_range(0, 3) != 0);
            re_r = ($urandom_range(0, 3) == 0);
         end else begin
            we_r = ($urandom_range(0, 3) == 0);
            re_r = ($urandom_range(0, 3) != 0);
         end
         d = 8'($urandom);
         drive(clr_r, we_r, re_r, d);
         check_model($sformatf("rand%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
